paddle_mode_ctrl: RTL and testbench
===================================

Name: paddle_mode_ctrl

Overview:
Game-mode sequencer for the two paddle datapaths. Selects whether the paddle Y positions come from the demo paddle generator (attract mode) or from the player buttons (play). It owns the movement tick, clamps positions to the playfield, handles pause, and drops back to attract after an idle timeout. It sits between the button debouncers / demo paddle generator and the renderer / collision logic.

Parameters:
TICK_DIV, 262144, clk cycles per movement tick (counter wraps at TICK_DIV-1)
Y_MIN, 62, minimum legal paddle Y
Y_MAX, 418, maximum legal paddle Y
Y_CENTER, 240, paddle Y loaded on entry to READY
STEP, 2, pixels moved per tick per pressed direction
READY_TICKS, 64, ticks spent in READY before PLAY
IDLE_TICKS, 1024, consecutive button-free PLAY ticks before returning to ATTRACT

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  start/resume button, level, debounced
pause  in  1  pause button, level, debounced; acts on rising edge only
p1_up  in  1  player 1 up, level
p1_dn  in  1  player 1 down, level
p2_up  in  1  player 2 up, level
p2_dn  in  1  player 2 down, level
demo_p1_y  in  11  player 1 Y from demo generator
demo_p2_y  in  11  player 2 Y from demo generator
p1_y  out  11  selected player 1 paddle Y
p2_y  out  11  selected player 2 paddle Y
demo_en  out  1  enable for the demo generator
mode  out  2  0=ATTRACT 1=READY 2=PLAY 3=PAUSE
tick  out  1  one-cycle movement tick pulse

Behaviour:
- All state updates on posedge clk; rst is synchronous and active-high, and has priority over everything.
- Reset values: mode=ATTRACT, demo_en=1, internal p1/p2 registers=Y_CENTER, tick=0, tick counter=0, idle counter=0, ready counter=0, pause edge register=0.
- Tick counter: free-running 0..TICK_DIV-1 in every state. tick=1 for exactly the cycle in which the counter equals TICK_DIV-1.
- ATTRACT: demo_en=1; p1_y/p2_y pass demo_p1_y/demo_p2_y through combinationally. start=1 -> READY on the next cycle.
- READY: demo_en=0; internal p1/p2 are loaded to Y_CENTER on entry; buttons are ignored. The ready counter increments on each tick. On the tick that makes the count equal READY_TICKS -> PLAY, with the counter cleared.
- PLAY: outputs come from the internal registers. On tick, each paddle is processed independently:
  - up only: y-STEP
  - down only: y+STEP
  - both or neither: no move
  - The result is clamped to [Y_MIN,Y_MAX]. Arithmetic is 12-bit signed before the clamp, so there is no 11-bit wrap.
- Idle counter (PLAY only): on a tick, it clears if any of the 4 direction inputs is high, otherwise it increments. When it reaches IDLE_TICKS -> ATTRACT (counter cleared, demo_en=1 next cycle).
- A pause rising edge in PLAY -> PAUSE. It has priority over an idle timeout in the same cycle, and the idle counter is held, not cleared.
- PAUSE: positions frozen; ticks ignored; idle counter not counting. A pause rising edge or start=1 -> PLAY.
- Pause edge detect: register the previous pause level; edge = pause & ~prev. A held pause causes exactly one transition.
- mode, demo_en and the position registers change only on a clock edge. p1_y/p2_y in ATTRACT are the only combinational path.

Optional Feature:
PADDLE_CPU_P2_EN:
- Defined:
  - In READY/PLAY/PAUSE, demo_en stays 1 and p2_y = demo_p2_y (CPU opponent).
  - p2_up/p2_dn are ignored for movement and for the idle counter.
  - In PAUSE, p2_y holds the value captured at PAUSE entry.
- Not defined: two-player behaviour exactly as in Behaviour.

Test Plan:
1. Reset with TICK_DIV=4 -> mode=0, demo_en=1, tick=0; demo_p1_y=100 gives p1_y=100 the same cycle; tick first pulses on cycle 4 after reset release.
2. start=1 for 1 cycle in ATTRACT with READY_TICKS=2 -> mode=1, p1_y=p2_y=240; mode=2 on the 2nd tick.
3. PLAY, p1_up held with STEP=2 from Y=66 -> 64, 62, then stays 62; p2_dn held from 416 -> 418, stays 418; p1_up+p1_dn together -> no change.
4. PLAY, no buttons, IDLE_TICKS=3 -> mode=0 after 3rd tick, demo_en=1; a press on the 2nd tick restarts the count.
5. pause held 10 cycles in PLAY -> single PAUSE entry; ticks do not move paddles; start=1 -> PLAY, positions unchanged. Pause edge coincident with idle-expiry tick -> mode=3.
6. rst asserted in PAUSE with p1 at 300 -> next cycle mode=0, demo_en=1, internal p1=240.

Source files
------------

// File: rtl/paddle_mode_ctrl.sv
// Paddle game-mode sequencer: ATTRACT / READY / PLAY / PAUSE, movement tick, clamping, idle timeout.
// Optional CPU opponent on paddle 2 is enabled by defining PADDLE_CPU_P2_EN.
module paddle_mode_ctrl #(
    parameter int TICK_DIV    = 262144,
    parameter int Y_MIN       = 62,
    parameter int Y_MAX       = 418,
    parameter int Y_CENTER    = 240,
    parameter int STEP        = 2,
    parameter int READY_TICKS = 64,
    parameter int IDLE_TICKS  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        p1_up,
    input  logic        p1_dn,
    input  logic        p2_up,
    input  logic        p2_dn,
    input  logic [10:0] demo_p1_y,
    input  logic [10:0] demo_p2_y,
    output logic [10:0] p1_y,
    output logic [10:0] p2_y,
    output logic        demo_en,
    output logic [1:0]  mode,
    output logic        tick
);

`ifdef PADDLE_CPU_P2_EN
    localparam logic CPU_P2 = 1'b1;
`else
    localparam logic CPU_P2 = 1'b0;
`endif

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = $clog2(READY_TICKS + 1);
    localparam int IW = $clog2(IDLE_TICKS + 1);

    localparam logic [TW-1:0]       TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [RW-1:0]       READY_LAST = RW'(READY_TICKS - 1);
    localparam logic [IW-1:0]       IDLE_LAST  = IW'(IDLE_TICKS - 1);
    localparam logic [10:0]         Y_CTR      = 11'(Y_CENTER);
    localparam logic signed [11:0]  STEP_S     = 12'(STEP);
    localparam logic signed [11:0]  YMIN_S     = 12'(Y_MIN);
    localparam logic signed [11:0]  YMAX_S     = 12'(Y_MAX);

    typedef enum logic [1:0] {
        ST_ATTRACT = 2'd0,
        ST_READY   = 2'd1,
        ST_PLAY    = 2'd2,
        ST_PAUSE   = 2'd3
    } state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] tick_cnt_nxt;
    logic [RW-1:0] ready_cnt;
    logic [IW-1:0] idle_cnt;
    logic          pause_prev;
    logic          pause_edge;
    logic [10:0]   p1_reg;
    logic [10:0]   p2_reg;
    logic          p2_up_eff;
    logic          p2_dn_eff;
    logic          any_btn;

    // Moves are computed in 12-bit signed so a step below zero cannot wrap.
    function automatic logic [10:0] move_y(input logic [10:0] y, input logic up, input logic dn);
        logic signed [11:0] v;
        v = $signed({1'b0, y});
        if (up && !dn)
            v = v - STEP_S;
        else if (dn && !up)
            v = v + STEP_S;
        if (v < YMIN_S)
            v = YMIN_S;
        else if (v > YMAX_S)
            v = YMAX_S;
        return v[10:0];
    endfunction

    assign pause_edge   = pause & ~pause_prev;
    assign p2_up_eff    = p2_up & ~CPU_P2;
    assign p2_dn_eff    = p2_dn & ~CPU_P2;
    assign any_btn      = p1_up | p1_dn | p2_up_eff | p2_dn_eff;
    assign tick_cnt_nxt = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_ATTRACT;
            demo_en    <= 1'b1;
            p1_reg     <= Y_CTR;
            p2_reg     <= Y_CTR;
            tick       <= 1'b0;
            tick_cnt   <= '0;
            ready_cnt  <= '0;
            idle_cnt   <= '0;
            pause_prev <= 1'b0;
        end else begin
            pause_prev <= pause;
            tick_cnt   <= tick_cnt_nxt;
            tick       <= (tick_cnt_nxt == TICK_LAST);

            case (state)
                ST_ATTRACT: begin
                    if (start) begin
                        state     <= ST_READY;
                        demo_en   <= CPU_P2;
                        p1_reg    <= Y_CTR;
                        p2_reg    <= Y_CTR;
                        ready_cnt <= '0;
                        idle_cnt  <= '0;
                    end
                end
                ST_READY: begin
                    if (tick) begin
                        if (ready_cnt == READY_LAST) begin
                            state     <= ST_PLAY;
                            ready_cnt <= '0;
                        end else begin
                            ready_cnt <= ready_cnt + 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    // A pause edge wins the cycle outright: no move, idle count held.
                    if (pause_edge) begin
                        state <= ST_PAUSE;
                        if (CPU_P2)
                            p2_reg <= demo_p2_y;
                    end else if (tick) begin
                        p1_reg <= move_y(p1_reg, p1_up, p1_dn);
                        if (!CPU_P2)
                            p2_reg <= move_y(p2_reg, p2_up_eff, p2_dn_eff);
                        if (any_btn) begin
                            idle_cnt <= '0;
                        end else if (idle_cnt == IDLE_LAST) begin
                            idle_cnt <= '0;
                            state    <= ST_ATTRACT;
                            demo_en  <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (pause_edge || start)
                        state <= ST_PLAY;
                end
                default: state <= ST_ATTRACT;
            endcase
        end
    end

    assign mode = state;
    assign p1_y = (state == ST_ATTRACT) ? demo_p1_y : p1_reg;

    always_comb begin
        p2_y = p2_reg;
        if (state == ST_ATTRACT)
            p2_y = demo_p2_y;
        else if (CPU_P2 && state != ST_PAUSE)
            p2_y = demo_p2_y;
    end

endmodule

// File: tb/tb_paddle_mode_ctrl.sv
// Self-checking bench for paddle_mode_ctrl (two-player build): per-cycle reference model,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_paddle_mode_ctrl;
    localparam int TICK_DIV    = 4;
    localparam int Y_MIN       = 62;
    localparam int Y_MAX       = 418;
    localparam int Y_CENTER    = 240;
    localparam int STEP        = 2;
    localparam int READY_TICKS = 2;
    localparam int IDLE_TICKS  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, pause = 1'b0;
    logic        p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
    logic [10:0] demo_p1_y = 11'd100, demo_p2_y = 11'd200;
    logic [10:0] p1_y, p2_y;
    logic        demo_en;
    logic [1:0]  mode;
    logic        tick;

    int errors = 0;
    int checks = 0;

    paddle_mode_ctrl #(
        .TICK_DIV(TICK_DIV), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX), .Y_CENTER(Y_CENTER),
        .STEP(STEP), .READY_TICKS(READY_TICKS), .IDLE_TICKS(IDLE_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause),
        .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
        .demo_p1_y(demo_p1_y), .demo_p2_y(demo_p2_y),
        .p1_y(p1_y), .p2_y(p2_y), .demo_en(demo_en), .mode(mode), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode as 0..3, counts as plain integers, tick from elapsed cycles.
    int m_mode, m_p1, m_p2, m_cyc, m_ready, m_idle;
    bit m_prev, m_valid = 0;

    function automatic int mv(input int y, input bit up, input bit dn);
        int v;
        v = y;
        if (up && !dn) v = v - STEP;
        if (dn && !up) v = v + STEP;
        if (v < Y_MIN) v = Y_MIN;
        if (v > Y_MAX) v = Y_MAX;
        return v;
    endfunction

    always @(posedge clk) begin
        bit tk, pe;
        if (rst) begin
            m_mode = 0; m_p1 = Y_CENTER; m_p2 = Y_CENTER;
            m_cyc = 0; m_ready = 0; m_idle = 0; m_prev = 0; m_valid = 1;
        end else if (m_valid) begin
            tk = (m_cyc % TICK_DIV) == TICK_DIV - 1;
            pe = pause && !m_prev;
            case (m_mode)
                0: if (start) begin
                    m_mode = 1; m_p1 = Y_CENTER; m_p2 = Y_CENTER; m_ready = 0;
                end
                1: if (tk) begin
                    m_ready++;
                    if (m_ready == READY_TICKS) begin m_mode = 2; m_ready = 0; end
                end
                2: if (pe) m_mode = 3;
                   else if (tk) begin
                    m_p1 = mv(m_p1, p1_up, p1_dn);
                    m_p2 = mv(m_p2, p2_up, p2_dn);
                    if (p1_up || p1_dn || p2_up || p2_dn) m_idle = 0;
                    else begin
                        m_idle++;
                        if (m_idle == IDLE_TICKS) begin m_mode = 0; m_idle = 0; end
                    end
                end
                default: if (pe || start) m_mode = 2;
            endcase
            m_cyc++;
            m_prev = pause;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("mode", mode, m_mode);
            chk("demo_en", demo_en, (m_mode == 0) ? 1 : 0);
            chk("tick", tick, ((m_cyc % TICK_DIV) == TICK_DIV - 1) ? 1 : 0);
            chk("p1_y", p1_y, (m_mode == 0) ? int'(demo_p1_y) : m_p1);
            chk("p2_y", p2_y, (m_mode == 0) ? int'(demo_p2_y) : m_p2);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mode(input int m, input int budget, input string name);
        int n = 0;
        while (int'(mode) != m && n < budget) begin
            cyc();
            n++;
        end
        chk(name, mode, m);
    endtask

    task automatic press_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) cyc();
        rst = 1'b0;
        // Reset values and pass-through in ATTRACT
        chk("rst_mode", mode, 0);
        chk("rst_demo_en", demo_en, 1);
        chk("rst_tick", tick, 0);
        chk("rst_p1_pass", p1_y, 100);
        cyc(); cyc();
        chk("tick_not_yet", tick, 0);
        cyc();
        chk("tick_first", tick, 1);
        cyc();
        chk("tick_one_cycle", tick, 0);

        // ATTRACT -> READY -> PLAY
        press_start();
        chk("ready_mode", mode, 1);
        chk("ready_p1", p1_y, 240);
        chk("ready_p2", p2_y, 240);
        chk("ready_demo_en", demo_en, 0);
        wait_mode(2, 20, "reach_play");

        // Exactly three ticks occur in any 12 consecutive cycles
        p1_up = 1'b1; p2_dn = 1'b1;
        repeat (12) cyc();
        chk("p1_three_steps", p1_y, 234);
        chk("p2_three_steps", p2_y, 246);
        repeat (400) cyc();
        chk("p1_clamp_min", p1_y, 62);
        chk("p2_clamp_max", p2_y, 418);
        p1_dn = 1'b1;
        repeat (20) cyc();
        chk("p1_both_hold", p1_y, 62);
        chk("p2_stay_max", p2_y, 418);

        // Idle timeout back to ATTRACT
        p1_up = 1'b0; p1_dn = 1'b0; p2_dn = 1'b0;
        wait_mode(0, 20, "idle_timeout");
        chk("idle_demo_en", demo_en, 1);
        chk("idle_p1_pass", p1_y, 100);

        // Held pause gives a single PAUSE entry, start resumes
        p1_dn = 1'b1;
        press_start();
        wait_mode(2, 20, "reach_play2");
        pause = 1'b1;
        repeat (10) cyc();
        chk("pause_held", mode, 3);
        pause = 1'b0;
        repeat (20) cyc();
        chk("pause_stays", mode, 3);
        press_start();
        chk("resume", mode, 2);

        // Pause edge on the same cycle as an idle expiry tick
        p1_dn = 1'b0;
        n = 0;
        while (!(m_mode == 2 && m_idle == IDLE_TICKS - 1 && (m_cyc % TICK_DIV) == TICK_DIV - 1)
               && n < 100) begin
            cyc();
            n++;
        end
        pause = 1'b1;
        cyc();
        chk("pause_beats_idle", mode, 3);
        pause = 1'b0;
        cyc();
        press_start();
        chk("resume2", mode, 2);
        wait_mode(0, 8, "idle_held_expires");

        // Reset while paused
        press_start();
        wait_mode(2, 20, "reach_play3");
        p1_dn = 1'b1;
        repeat (40) cyc();
        pause = 1'b1;
        cyc();
        chk("pause_before_rst", mode, 3);
        pause = 1'b0; p1_dn = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_pause_mode", mode, 0);
        chk("rst_pause_demo_en", demo_en, 1);
        chk("rst_pause_tick", tick, 0);
        press_start();
        chk("rst_then_center", p1_y, 240);

        // Randomized stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 599) == 0);
            start     = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) pause = ~pause;
            p1_up     = ($urandom_range(0, 4) == 0);
            p1_dn     = ($urandom_range(0, 4) == 0);
            p2_up     = ($urandom_range(0, 4) == 0);
            p2_dn     = ($urandom_range(0, 4) == 0);
            demo_p1_y = 11'($urandom_range(0, 2047));
            demo_p2_y = 11'($urandom_range(0, 2047));
            cyc();
        end
        rst = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
